// File: rtl/dac_sample_sequencer_if.sv
// Handshake bundle between a waveform controller (master) and dac_sample_sequencer (slave).
// DIV_W must match the sequencer's divider width.
interface dac_sample_sequencer_if #(
  parameter int unsigned DIV_W = 16
) ();
  logic             enable;
  logic [1:0]       mode;
  logic [11:0]      step;
  logic [DIV_W-1:0] period;
  logic             dac_done;
  logic             start;
  logic [11:0]      code;
  logic [15:0]      sample_cnt;
  logic             underrun;

  modport master (
    output enable, mode, step, period, dac_done,
    input  start, code, sample_cnt, underrun
  );

  modport slave (
    input  enable, mode, step, period, dac_done,
    output start, code, sample_cnt, underrun
  );
endinterface

// File: rtl/dac_sample_sequencer.sv
// Periodic DAC sample generator (ramp/triangle/square/constant) handing codes to an SPI DAC stage.
// Define SEQ_TRIANGLE_EN to build triangle mode; otherwise mode 01 behaves as ramp.
module dac_sample_sequencer #(
  parameter int unsigned START_LEN = 4,
  parameter int unsigned DIV_W     = 16
) (
  input logic                   clock_in,
  input logic                   reset_n,
  dac_sample_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWaitTick, StIssue, StWaitDone} state_e;

  localparam logic [7:0] LenLast = 8'(START_LEN - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [7:0]       len_q, len_d;
  logic [11:0]      code_q, code_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             underrun_q, underrun_d;
  logic             sq_hi_q, sq_hi_d;
`ifdef SEQ_TRIANGLE_EN
  logic             dir_down_q, dir_down_d, dir_down_nxt;
`endif

  logic        tick;
  logic [12:0] sum;
  logic [11:0] nxt_code;
  logic        sq_hi_nxt;

  assign tick = (div_q == period_q);

  // Candidate waveform value, committed only on an accepted tick.
  always_comb begin
    sum       = {1'b0, code_q} + {1'b0, bus.step};
    nxt_code  = sum[11:0];
    sq_hi_nxt = sq_hi_q;
`ifdef SEQ_TRIANGLE_EN
    dir_down_nxt = dir_down_q;
`endif
    case (bus.mode)
      2'b00: nxt_code = sum[11:0];
`ifdef SEQ_TRIANGLE_EN
      2'b01: begin
        if (!dir_down_q) begin
          if (sum >= 13'd4095) begin
            nxt_code     = 12'hFFF;
            dir_down_nxt = 1'b1;
          end else begin
            nxt_code = sum[11:0];
          end
        end else if (code_q <= bus.step) begin
          nxt_code     = 12'h000;
          dir_down_nxt = 1'b0;
        end else begin
          nxt_code = code_q - bus.step;
        end
      end
`else
      2'b01: nxt_code = sum[11:0];
`endif
      2'b10: begin
        nxt_code  = sq_hi_q ? 12'h000 : bus.step;
        sq_hi_nxt = ~sq_hi_q;
      end
      2'b11: nxt_code = bus.step;
      default: nxt_code = sum[11:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    period_d   = period_q;
    len_d      = len_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    underrun_d = underrun_q;
    sq_hi_d    = sq_hi_q;
`ifdef SEQ_TRIANGLE_EN
    dir_down_d = dir_down_q;
`endif

    // Divider free-runs outside IDLE so ticks missed during a transfer are detectable.
    if (state_q != StIdle) begin
      if (tick) begin
        div_d    = '0;
        period_d = bus.period;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (state_q)
      StIdle: begin
        div_d   = '0;
        sq_hi_d = 1'b0;
        if (bus.enable) begin
          state_d  = StWaitTick;
          period_d = bus.period;
        end
      end
      StWaitTick: begin
        if (!bus.enable) begin
          state_d = StIdle;
          div_d   = '0;
        end else if (tick) begin
          code_d  = nxt_code;
          sq_hi_d = sq_hi_nxt;
`ifdef SEQ_TRIANGLE_EN
          dir_down_d = dir_down_nxt;
`endif
          len_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (tick) underrun_d = 1'b1;
        if (len_q == LenLast) begin
          state_d = StWaitDone;
        end else begin
          len_d = len_q + 8'd1;
        end
      end
      StWaitDone: begin
        if (tick) underrun_d = 1'b1;
        if (bus.dac_done) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = bus.enable ? StWaitTick : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      period_q   <= '0;
      len_q      <= '0;
      code_q     <= '0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
      sq_hi_q    <= 1'b0;
`ifdef SEQ_TRIANGLE_EN
      dir_down_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      period_q   <= period_d;
      len_q      <= len_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
      sq_hi_q    <= sq_hi_d;
`ifdef SEQ_TRIANGLE_EN
      dir_down_q <= dir_down_d;
`endif
    end
  end

  // start decodes straight from state so an asynchronous reset drops it immediately.
  assign bus.start      = (state_q == StIssue);
  assign bus.code       = code_q;
  assign bus.sample_cnt = cnt_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Scoreboard bench for dac_sample_sequencer: expected codes queued at stimulus, popped on start.
// Honours SEQ_TRIANGLE_EN for the triangle expectations.
`timescale 1ns/1ps
module tb_dac_sample_sequencer;

  localparam int unsigned StartLen = 4;
  localparam int unsigned DivW     = 16;

`ifdef SEQ_TRIANGLE_EN
  localparam int unsigned TriN = 7;
  localparam logic [11:0] TriExp [TriN] =
    '{12'h600, 12'hC00, 12'hFFF, 12'h9FF, 12'h3FF, 12'h000, 12'h600};
`else
  localparam int unsigned TriN = 3;
  localparam logic [11:0] TriExp [TriN] = '{12'h600, 12'hC00, 12'h200};
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_sample_sequencer_if #(.DIV_W(DivW)) bus ();

  dac_sample_sequencer #(
    .START_LEN(StartLen),
    .DIV_W    (DivW)
  ) dut (
    .clock_in(clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned n_starts = 0;
  int unsigned last_rise = 0;
  int unsigned exp_gap  = 0;
  int unsigned dac_dly  = 5;
  logic [11:0] exp_q [$];

  // Pops the scoreboard on each start rise; checks width, hold and tick spacing.
  task automatic monitor();
    logic        prev = 1'b0;
    int unsigned hi   = 0;
    logic [11:0] rise_code = '0;
    logic [11:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.start && !prev) begin
        n_starts++;
        rise_code = bus.code;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL code_unexpected: start with code %h, none expected", bus.code);
        end else begin
          e = exp_q.pop_front();
          if (bus.code !== e) begin
            n_fail++;
            $display("FAIL code: got %h required %h", bus.code, e);
          end
        end
        if (exp_gap != 0 && last_rise != 0) begin
          n_checks++;
          if (cyc - last_rise != exp_gap) begin
            n_fail++;
            $display("FAIL tick_gap: got %0d cycles required %0d", cyc - last_rise, exp_gap);
          end
        end
        last_rise = cyc;
      end
      if (!bus.start && prev && rst_n) begin
        n_checks += 2;
        if (hi != StartLen) begin
          n_fail++;
          $display("FAIL start_len: got %0d cycles required %0d", hi, StartLen);
        end
        if (bus.code !== rise_code) begin
          n_fail++;
          $display("FAIL code_hold: got %h required %h", bus.code, rise_code);
        end
      end
      if (!bus.start || !rst_n) hi = 0;
      if (bus.start) hi++;
      prev = bus.start;
    end
  endtask

  // DAC stage model: one-cycle dac_done sampled dac_dly clocks after start falls.
  task automatic dac_model();
    logic        prev = 1'b0;
    int unsigned left = 0;
    forever begin
      @(negedge clk);
      bus.dac_done = 1'b0;
      if (!rst_n) left = 0;
      else if (prev && !bus.start) left = dac_dly;
      if (left != 0) begin
        left--;
        if (left == 0) bus.dac_done = 1'b1;
      end
      prev = bus.start;
    end
  endtask

  task automatic watchdog();
    #500us;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  endtask

  task automatic wait_starts(input int unsigned target, input int unsigned budget,
                             input string what);
    int unsigned t = 0;
    while (n_starts < target && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    if (n_starts < target) begin
      n_fail++;
      $display("FAIL %s_starts: timeout with %0d starts, required %0d", what, n_starts, target);
    end
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int unsigned budget,
                          input string what);
    int unsigned t = 0;
    while (bus.sample_cnt !== target && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    if (bus.sample_cnt !== target) begin
      n_fail++;
      $display("FAIL %s_cnt: timeout with sample_cnt %0d, required %0d", what, bus.sample_cnt,
               target);
    end
  endtask

  task automatic wait_fall(input int unsigned budget, input string what);
    int unsigned t = 0;
    while (bus.start && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    if (bus.start) begin
      n_fail++;
      $display("FAIL %s_fall: start still high after %0d cycles, required low", what, budget);
    end
  endtask

  task automatic apply_reset();
    bus.enable = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    n_starts  = 0;
    last_rise = 0;
    exp_gap   = 0;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [11:0] s, input logic [DivW-1:0] p,
                         input int unsigned d);
    bus.mode   = m;
    bus.step   = s;
    bus.period = p;
    dac_dly    = d;
  endtask

  // Enables for n more transfers, dropping enable as the last one issues.
  task automatic run_samples(input int unsigned n, input string what);
    int unsigned s0 = n_starts;
    logic [15:0] c0 = bus.sample_cnt;
    bus.enable = 1'b1;
    wait_starts(s0 + n, 400, what);
    bus.enable = 1'b0;
    wait_cnt(c0 + 16'(n), 200, what);
    repeat (20) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks += 4;
    if (bus.start !== 1'b0) begin
      n_fail++; $display("FAIL reset_start: got %b required 0", bus.start);
    end
    if (bus.code !== 12'h000) begin
      n_fail++; $display("FAIL reset_code: got %h required 000", bus.code);
    end
    if (bus.sample_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d required 0", bus.sample_cnt);
    end
    if (bus.underrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_underrun: got %b required 0", bus.underrun);
    end
  endtask

  task automatic test_ramp();
    apply_reset();
    set_cfg(2'b00, 12'h400, 16'd9, 5);
    exp_gap = 10;
    exp_q.push_back(12'h400); exp_q.push_back(12'h800);
    exp_q.push_back(12'hC00); exp_q.push_back(12'h000);
    run_samples(4, "ramp");
    exp_gap = 0;
    n_checks += 4;
    if (bus.underrun !== 1'b0) begin
      n_fail++; $display("FAIL ramp_underrun: got %b required 0", bus.underrun);
    end
    if (bus.sample_cnt !== 16'd4) begin
      n_fail++; $display("FAIL ramp_cnt: got %0d required 4", bus.sample_cnt);
    end
    if (n_starts != 4) begin
      n_fail++; $display("FAIL ramp_starts: got %0d required 4", n_starts);
    end
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL ramp_pending: got %0d codes left required 0", exp_q.size());
    end
  endtask

  task automatic test_triangle();
    apply_reset();
    set_cfg(2'b01, 12'h600, 16'd9, 5);
    for (int i = 0; i < int'(TriN); i++) exp_q.push_back(TriExp[i]);
    run_samples(TriN, "triangle");
    n_checks += 3;
    if (bus.sample_cnt !== 16'(TriN)) begin
      n_fail++; $display("FAIL tri_cnt: got %0d required %0d", bus.sample_cnt, TriN);
    end
    if (bus.underrun !== 1'b0) begin
      n_fail++; $display("FAIL tri_underrun: got %b required 0", bus.underrun);
    end
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL tri_pending: got %0d codes left required 0", exp_q.size());
    end
  endtask

  task automatic test_square();
    apply_reset();
    set_cfg(2'b10, 12'h800, 16'd9, 5);
    exp_q.push_back(12'h800); exp_q.push_back(12'h000); exp_q.push_back(12'h800);
    run_samples(3, "square");
    // Back in IDLE after a high sample: the restart must still begin high.
    exp_q.push_back(12'h800);
    run_samples(1, "square_reenable");
    n_checks += 2;
    if (bus.sample_cnt !== 16'd4) begin
      n_fail++; $display("FAIL square_cnt: got %0d required 4", bus.sample_cnt);
    end
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL square_pending: got %0d codes left required 0", exp_q.size());
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    set_cfg(2'b00, 12'h001, 16'd9, 5);
    exp_q.push_back(12'h001);
    bus.enable = 1'b1;
    wait_starts(1, 100, "drop");
    bus.enable = 1'b0;
    wait_cnt(16'd1, 100, "drop");
    repeat (40) @(negedge clk);
    #1;
    n_checks += 3;
    if (n_starts != 1) begin
      n_fail++; $display("FAIL drop_starts: got %0d required 1", n_starts);
    end
    if (bus.sample_cnt !== 16'd1) begin
      n_fail++; $display("FAIL drop_cnt: got %0d required 1", bus.sample_cnt);
    end
    if (bus.start !== 1'b0) begin
      n_fail++; $display("FAIL drop_idle_start: got %b required 0", bus.start);
    end
  endtask

  task automatic test_underrun();
    apply_reset();
    set_cfg(2'b11, 12'h123, 16'd2, 20);
    for (int i = 0; i < 3; i++) exp_q.push_back(12'h123);
    run_samples(3, "underrun");
    n_checks += 3;
    if (bus.underrun !== 1'b1) begin
      n_fail++; $display("FAIL underrun_set: got %b required 1", bus.underrun);
    end
    if (bus.sample_cnt !== 16'd3) begin
      n_fail++; $display("FAIL underrun_cnt: got %0d required 3", bus.sample_cnt);
    end
    if (n_starts != 3) begin
      n_fail++; $display("FAIL underrun_starts: got %0d required 3", n_starts);
    end
    repeat (30) @(negedge clk);
    #1;
    n_checks++;
    if (bus.underrun !== 1'b1) begin
      n_fail++; $display("FAIL underrun_sticky: got %b required 1", bus.underrun);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_cfg(2'b00, 12'h100, 16'd9, 5);
    exp_q.push_back(12'h100); exp_q.push_back(12'h200);
    bus.enable = 1'b1;
    wait_cnt(16'd1, 100, "rmid_first");
    dac_dly = 30;
    wait_starts(2, 100, "rmid");
    wait_fall(20, "rmid");
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.code !== 12'h200) begin
      n_fail++; $display("FAIL rmid_pre_code: got %h required 200", bus.code);
    end
    // Assert reset well away from a rising edge and look before the next one.
    #1 rst_n = 1'b0;
    bus.enable = 1'b0;
    #1;
    n_checks += 4;
    if (bus.start !== 1'b0) begin
      n_fail++; $display("FAIL rmid_start: got %b required 0", bus.start);
    end
    if (bus.code !== 12'h000) begin
      n_fail++; $display("FAIL rmid_code: got %h required 000", bus.code);
    end
    if (bus.sample_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rmid_cnt: got %0d required 0", bus.sample_cnt);
    end
    if (bus.underrun !== 1'b0) begin
      n_fail++; $display("FAIL rmid_underrun: got %b required 0", bus.underrun);
    end
    repeat (2) @(negedge clk);
    exp_q.delete();
    n_starts  = 0;
    last_rise = 0;
    dac_dly   = 5;
    rst_n = 1'b1;
    @(negedge clk); #1;
    // Restart from IDLE, then reset inside ISSUE: start must fall without a clock edge.
    exp_q.push_back(12'h100);
    bus.enable = 1'b1;
    wait_starts(1, 100, "rmid_restart");
    n_checks++;
    if (bus.start !== 1'b1) begin
      n_fail++; $display("FAIL rmid_issue_pre: got start %b required 1", bus.start);
    end
    #1 rst_n = 1'b0;
    bus.enable = 1'b0;
    #1;
    n_checks += 2;
    if (bus.start !== 1'b0) begin
      n_fail++; $display("FAIL rmid_issue_start: got %b required 0", bus.start);
    end
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rmid_pending: got %0d codes left required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.mode     = 2'b00;
    bus.step     = 12'h000;
    bus.period   = '0;
    bus.dac_done = 1'b0;
    fork
      monitor();
      dac_model();
      watchdog();
    join_none
    test_reset();
    test_ramp();
    test_triangle();
    test_square();
    test_enable_drop();
    test_underrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_sample_sequencer.md
DAC_SAMPLE_SEQUENCER -- requirements
Module: dac_sample_sequencer

Interface
REQ-001 SHALL have parameter START_LEN, default 4, giving the number of cycles `start` is held high per sample (range 1..255).
REQ-002 SHALL have parameter DIV_W, default 16, giving the width of the sample-period divider.
REQ-003 SHALL have the port `clock_in`, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have the port `reset_n`, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have the port `enable`, input, 1 bit: 1 = generate samples, 0 = stop after the current transfer.
REQ-006 SHALL have the port `mode`, input, 2 bits: 00 ramp, 01 triangle, 10 square, 11 constant.
REQ-007 SHALL have the port `step`, input, 12 bits, the waveform increment (ramp/triangle), high level (square) or value (constant).
REQ-008 SHALL have the port `period`, input, DIV_W bits; the sample interval is period+1 clocks.
REQ-009 SHALL have the port `dac_done`, input, 1 bit, a one-cycle pulse from the downstream SPI DAC stage when its frame is complete.
REQ-010 SHALL have the port `start`, output, 1 bit, the transfer request to the DAC stage.
REQ-011 SHALL have the port `code`, output, 12 bits, the sample presented to the DAC stage.
REQ-012 SHALL have the port `sample_cnt`, output, 16 bits, the count of completed transfers.
REQ-013 SHALL have the port `underrun`, output, 1 bit, a sticky flag meaning a tick was missed while the DAC was busy.

Function
REQ-014 SHALL implement the states IDLE, WAIT_TICK, ISSUE and WAIT_DONE.
REQ-015 SHALL go from IDLE to WAIT_TICK when enable=1, clearing the divider to 0.
REQ-016 SHALL increment the divider every cycle in WAIT_TICK and raise a tick when divider==period; the divider then returns to 0.
REQ-017 SHALL, on a tick in WAIT_TICK, update `code` per mode on that edge and enter ISSUE.
REQ-018 SHALL assert `start`=1 throughout ISSUE for exactly START_LEN cycles, then enter WAIT_DONE with start=0.
REQ-019 SHALL hold `code` stable from entry to ISSUE until WAIT_DONE exits.
REQ-020 SHALL, in WAIT_DONE on dac_done=1, increment sample_cnt (wrapping modulo 2^16), then enter WAIT_TICK if enable=1, else IDLE.
REQ-021 SHALL keep the divider running in ISSUE and WAIT_DONE; a tick there sets underrun=1, the sample is dropped (no code update) and the divider restarts at 0.
REQ-022 SHALL ignore dac_done outside WAIT_DONE.
REQ-023 SHALL, when enable falls in WAIT_TICK, enter IDLE next cycle; a transfer in ISSUE or WAIT_DONE always completes and start is never truncated.
REQ-024 SHALL, in ramp mode, set code <= (code+step) mod 4096.
REQ-025 SHALL, in triangle mode, count up by step saturating at 4095, then down by step saturating at 0, reversing direction on each saturation.
REQ-026 SHALL, in square mode, alternate code between step and 0 on successive samples, with the first sample after IDLE equal to step.
REQ-027 SHALL, in constant mode, set code <= step.
REQ-028 SHALL sample mode, step and period only on tick edges; changes between ticks have no effect.
REQ-029 SHALL clear underrun only by reset.

Reset
REQ-030 SHALL, on reset_n=0, immediately force state=IDLE, start=0, code=0, sample_cnt=0, underrun=0, divider=0 and triangle direction=up.
REQ-031 SHALL, when reset is asserted mid-transfer, drop start asynchronously; no completion is counted.
REQ-032 SHALL release reset synchronously to clock_in by external logic; the block itself reacts to the release on the next clock_in edge.

Configuration
REQ-033 SHALL, with macro SEQ_TRIANGLE_EN defined, compile in triangle mode and its direction register.
REQ-034 SHALL, without SEQ_TRIANGLE_EN, compile out triangle mode so that mode 01 behaves exactly as ramp (mode 00).

Verification
REQ-035 SHALL cover: ramp, step=0x400, period=9, dac_done 5 cycles after start falls -> code 0x400,0x800,0xC00,0x000; start high 4 cycles per sample; ticks 10 cycles apart; no underrun.
REQ-036 SHALL cover: triangle with SEQ_TRIANGLE_EN, step=0x600 -> codes 0x600,0xC00,0xFFF,0x9FF,0x3FF,0x000,0x600; without the macro -> 0x600,0xC00,0x200.
REQ-037 SHALL cover: period=2 with dac_done delayed 20 cycles -> underrun=1 and stays 1; sample_cnt counts only completed transfers.
REQ-038 SHALL cover: enable dropped during ISSUE -> start still 4 cycles, IDLE after dac_done, sample_cnt +1, no further start.
REQ-039 SHALL cover: reset_n pulsed low while in WAIT_DONE -> start=0, code=0, sample_cnt=0 without waiting for a clock edge, restart from IDLE.
REQ-040 SHALL cover: square, step=0x800 -> codes 0x800,0x000,0x800; re-enable from IDLE -> first code 0x800.
